upd1771c_host_tx: RTL
=====================

Name: upd1771c_host_tx

Overview:
- Host-side command transmitter for the uPD1771C sound chip. It drives the chip's PA input port.
- Accepts command bytes from the SCV CPU bus glue over a valid/ready interface and buffers them in a small FIFO.
- Presents each byte on PA aligned to the chip's PHI2 phase. Holds it for a fixed window so the chip's PA sampling loop latches it, then inserts an inter-byte gap.
- Honours a busy flag from the chip's PB port before sending the next byte.

Parameters:
- DEPTH, 4: FIFO depth in bytes; must be a power of 2, at least 2.
- HOLD_CYC, 80: CKEN-qualified CLK cycles each byte is driven (8 setup + 72 sample window).
- GAP_CYC, 16: CKEN-qualified cycles of idle bus between bytes.

Ports:
- CLK  in  1  system clock.
- RESB  in  1  reset; asynchronous, active-low.
- CKEN  in  1  clock enable; all state advances only when high.
- PHI2P  in  1  single-cycle PHI2 phase strobe from the uPD1771C core.
- WR_DATA  in  8  command byte to queue.
- WR_VALID  in  1  WR_DATA is valid.
- WR_READY  out  1  FIFO can accept a byte.
- BUSY_I  in  1  chip busy (from PB); active-high; blocks the start of a byte.
- PA_O  out  8  byte driven to the chip's PA_I.
- PA_OE  out  1  PA_O is valid and driven.
- IDLE  out  1  FIFO empty and FSM in S_IDLE.
- LEVEL  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (RESB low, asynchronous):
  - FIFO flushed; LEVEL=0; WR_READY=1.
  - PA_O=8'h00, PA_OE=0, IDLE=1, FSM=S_IDLE.
  - Reset mid-byte aborts the byte immediately; PA_OE falls asynchronously.
- Push:
  - A byte is accepted on a CLK edge where CKEN & WR_VALID & WR_READY.
  - WR_READY = (LEVEL != DEPTH), derived from registered state.
  - With the FIFO full, WR_VALID is ignored and the byte is not stored. The producer must hold it.
- FSM states: S_IDLE, S_ALIGN, S_HOLD, S_GAP.
- S_IDLE:
  - If LEVEL != 0 and BUSY_I = 0, go to S_ALIGN. PA_OE=0.
- S_ALIGN:
  - Wait for CKEN & PHI2P.
  - On that edge: pop the FIFO head into the PA_O register, set PA_OE=1, load counter = HOLD_CYC-1, go to S_HOLD.
  - PA_O/PA_OE are valid from the cycle after the PHI2P edge.
  - If BUSY_I rises while in S_ALIGN, return to S_IDLE; nothing is popped.
- S_HOLD:
  - Decrement on each CKEN. PA_O is stable and BUSY_I is ignored.
  - When counter = 0 on a CKEN edge: PA_OE=0, PA_O=8'h00, counter = GAP_CYC-1, go to S_GAP.
  - PA_OE is therefore high for exactly HOLD_CYC enabled cycles.
- S_GAP:
  - Decrement on each CKEN. At 0, go to S_IDLE.
  - From S_IDLE, S_ALIGN is re-entered on the next enabled cycle if data is pending.
- Simultaneous push and pop in the same cycle: LEVEL is unchanged.
- A push to an empty FIFO is visible to the FSM the following cycle. Push-to-PA_OE latency is at least 2 enabled cycles plus the PHI2P wait.
- Counter width is $clog2(max(HOLD_CYC,GAP_CYC)). Counter and FIFO pointers wrap modulo their width; pointers are DEPTH-modulo.
- IDLE = (state == S_IDLE) & (LEVEL == 0).
- CKEN low freezes every register, including in S_HOLD.
- Bytes go out in FIFO order with no reordering or duplication.

Decomposition:
- Package upd1771c_host_tx_pkg: FSM state enum (S_IDLE, S_ALIGN, S_HOLD, S_GAP) and the default HOLD_CYC/GAP_CYC localparams shared with testbenches.
- Sub-module upd1771c_tx_fifo: synchronous DEPTH×8 FIFO.
  - Ports: CLK, RESB, CKEN, push/pop, dout, level.
  - Pop data is combinational from the head; registered pointers.
- The top level holds the FSM, counter and PA output register.

Test Plan:
- Single byte: write 8'h0f after reset, BUSY_I=0, CKEN=1.
  - PA_O=8'h0f with PA_OE=1 begins the cycle after the first PHI2P.
  - PA_OE stays high for exactly 80 cycles, then 16 gap cycles, then IDLE=1.
- Burst: write 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 back-to-back.
  - WR_READY drops when LEVEL=4 and the fifth byte is stalled until the first pop.
  - The output sequence is 01,02,03,04,05, each spaced at least 96 cycles apart and PHI2P-aligned.
- Busy gate: hold BUSY_I=1, then write 8'hA5.
  - PA_OE stays 0 and LEVEL=1.
  - Release BUSY_I: the byte goes out at the next PHI2P.
  - Raising BUSY_I during S_HOLD does not shorten the 80-cycle window.
- Clock enable: CKEN at a 1-in-3 duty.
  - The PA_OE window spans 240 CLK cycles; all timing scales with CKEN.
- Reset mid-hold: assert RESB low 20 cycles into a hold.
  - PA_OE=0, PA_O=00, LEVEL=0, WR_READY=1 immediately.
  - After release, no stale byte is ever driven.
- Push/pop collision: with LEVEL=2, push exactly on the pop cycle.
  - LEVEL stays 2 and order is preserved.

Source files
------------

// File: rtl/upd1771c_host_tx_pkg.sv
// Shared types and default timing for the uPD1771C host command transmitter.
package upd1771c_host_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_HOLD  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam int DEF_DEPTH    = 4;
    localparam int DEF_HOLD_CYC = 80;
    localparam int DEF_GAP_CYC  = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/upd1771c_host_tx_if.sv
// Command-byte write channel from the SCV bus glue into the transmitter.
interface upd1771c_host_tx_if;
    logic [7:0] WR_DATA;
    logic       WR_VALID;
    logic       WR_READY;

    modport master (output WR_DATA, output WR_VALID, input WR_READY);
    modport slave  (input WR_DATA, input WR_VALID, output WR_READY);
endinterface

// File: rtl/upd1771c_tx_fifo.sv
// Synchronous DEPTH x 8 command FIFO; head byte is presented combinationally.
module upd1771c_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESB,
    input  logic                     CKEN,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify requests with the enable and with occupancy so the pointers never overrun.
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (CKEN) begin
            do_push_s = push && (level_r != FULL_LVL);
            do_pop_s  = pop && (level_r != '0);
        end else begin
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge CLK) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign level = level_r;

endmodule

// File: rtl/upd1771c_host_tx.sv
// Drives queued command bytes onto the uPD1771C PA port, PHI2-aligned,
// holding each for a fixed sample window followed by an idle gap.
module upd1771c_host_tx
    import upd1771c_host_tx_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int GAP_CYC  = DEF_GAP_CYC
) (
    input  logic                   CLK,
    input  logic                   RESB,
    input  logic                   CKEN,
    input  logic                   PHI2P,
    upd1771c_host_tx_if.slave      wr,
    input  logic                   BUSY_I,
    output logic [7:0]             PA_O,
    output logic                   PA_OE,
    output logic                   IDLE,
    output logic [$clog2(DEPTH):0] LEVEL
);
    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int CW_RAW = $clog2(max_int(HOLD_CYC, GAP_CYC));
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [LW-1:0] level_s;
    logic [7:0]    head_s;
    logic          push_s;
    logic          pop_s;

    upd1771c_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .RESB  (RESB),
        .CKEN  (CKEN),
        .push  (push_s),
        .pop   (pop_s),
        .din   (wr.WR_DATA),
        .dout  (head_s),
        .level (level_s)
    );

    assign wr.WR_READY = (level_s != FULL_LVL);
    assign push_s      = wr.WR_VALID & wr.WR_READY;
    assign LEVEL       = level_s;
    assign IDLE        = (state_r == S_IDLE) && (level_s == '0);

    // The head leaves the FIFO only on the PHI2 edge that starts a byte; busy wins over PHI2.
    always_comb begin
        pop_s = 1'b0;
        if (CKEN && (state_r == S_ALIGN) && !BUSY_I && PHI2P) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Byte sequencer: wait for PHI2, drive the byte for the hold window, then idle the bus for the gap.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            PA_O    <= 8'h00;
            PA_OE   <= 1'b0;
        end else if (CKEN) begin
            case (state_r)
                S_IDLE: begin
                    PA_OE <= 1'b0;
                    PA_O  <= 8'h00;
                    if ((level_s != '0) && !BUSY_I) begin
                        state_r <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (BUSY_I) begin
                        state_r <= S_IDLE;
                    end else if (PHI2P) begin
                        PA_O    <= head_s;
                        PA_OE   <= 1'b1;
                        cnt_r   <= HOLD_LOAD;
                        state_r <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (cnt_r == '0) begin
                        PA_OE   <= 1'b0;
                        PA_O    <= 8'h00;
                        cnt_r   <= GAP_LOAD;
                        state_r <= S_GAP;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (cnt_r == '0) begin
                        state_r <= S_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    PA_OE   <= 1'b0;
                    PA_O    <= 8'h00;
                end
            endcase
        end
    end

endmodule
